// File: rtl/byte_pair_packer.sv
// Packs a byte stream into 16-bit {byte1, byte2} words behind a small output FIFO.
// Odd-length frames are closed with PAD_BYTE in byte2.
module byte_pair_packer #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] out_packed_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_padded,
  output logic        out_last,
  output logic [15:0] word_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {
    HIGH = 1'b0,
    LOW  = 1'b1
  } state_e;

  typedef struct packed {
    logic [15:0] data;
    logic        padded;
    logic        last;
  } entry_t;

  state_e        state_q, state_d;
  logic [7:0]    byte1_q, byte1_d;
  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [15:0]   word_count_q;

  logic   accept, pop, push, full;
  entry_t push_entry, head;

  assign full     = (count_q == DEPTH_C);
  assign in_ready = !rst && !full;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // State register; a held byte1 is discarded on reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HIGH;
      byte1_q <= 8'h00;
    end else begin
      state_q <= state_d;
      byte1_q <= byte1_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        HIGH:    state_d = in_last ? HIGH : LOW;
        LOW:     state_d = HIGH;
        default: state_d = HIGH;
      endcase
    end
  end

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    byte1_d    = byte1_q;
    if (accept) begin
      case (state_q)
        HIGH: begin
          if (in_last) begin
            push       = 1'b1;
            push_entry = '{data: {in_byte, PAD_BYTE}, padded: 1'b1, last: 1'b1};
          end else begin
            byte1_d = in_byte;
          end
        end
        LOW: begin
          push       = 1'b1;
          push_entry = '{data: {byte1_q, in_byte}, padded: 1'b0, last: in_last};
        end
        default: ;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the cleared count masks stale entries from the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      word_count_q <= 16'h0000;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + AW'(1);
        word_count_q <= word_count_q + 16'h0001;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign out_valid       = (count_q != '0);
  assign out_packed_data = out_valid ? head.data   : 16'h0000;
  assign out_padded      = out_valid ? head.padded : 1'b0;
  assign out_last        = out_valid ? head.last   : 1'b0;
  assign word_count      = word_count_q;

endmodule

// File: tb/tb_byte_pair_packer.sv
// Directed bench for byte_pair_packer: per-cycle vector table plus reset, padding and wrap sequences.
module tb_byte_pair_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid, in_last, in_ready;
  logic [15:0] out_packed_data;
  logic        out_valid, out_ready, out_padded, out_last;
  logic [15:0] word_count;

  logic [7:0]  ff_in_byte;
  logic        ff_in_valid, ff_in_last, ff_in_ready;
  logic [15:0] ff_out_packed_data;
  logic        ff_out_valid, ff_out_ready, ff_out_padded, ff_out_last;
  logic [15:0] ff_word_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_pair_packer #(.FIFO_DEPTH(2), .PAD_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_packed_data(out_packed_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_padded(out_padded), .out_last(out_last),
    .word_count(word_count)
  );

  byte_pair_packer #(.FIFO_DEPTH(2), .PAD_BYTE(8'hFF)) dut_ff (
    .clk(clk), .rst(rst), .in_byte(ff_in_byte), .in_valid(ff_in_valid), .in_last(ff_in_last),
    .in_ready(ff_in_ready), .out_packed_data(ff_out_packed_data), .out_valid(ff_out_valid),
    .out_ready(ff_out_ready), .out_padded(ff_out_padded), .out_last(ff_out_last),
    .word_count(ff_word_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        v;
    logic        l;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_data;
    logic        e_pad;
    logic        e_last;
    logic        e_irdy;
    logic [15:0] e_wc;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  initial begin
    //            byte   v     l     ordy  ov    data      pad   last  irdy  wc
    vecs[0]  = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[1]  = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA53C, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[2]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[3]  = '{8'h7E, 1'b1, 1'b1, 1'b0, 1'b1, 16'h7E00, 1'b1, 1'b1, 1'b1, 16'd1};
    vecs[4]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[5]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[6]  = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[7]  = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[8]  = '{8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b0, 16'd2};
    // FIFO full: byte 05 is refused and the head word holds for five cycles
    vecs[9]  = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[10] = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[11] = '{8'hEE, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[12] = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[13] = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[14] = '{8'h05, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0304, 1'b0, 1'b0, 1'b1, 16'd3};
    vecs[15] = '{8'h05, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd4};
    vecs[16] = '{8'h06, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0506, 1'b0, 1'b1, 1'b1, 16'd4};
    // push and pop together with one entry queued: occupancy stays at one
    vecs[17] = '{8'h09, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0900, 1'b1, 1'b1, 1'b1, 16'd5};
    vecs[18] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd6};
  end

  initial begin
    bit reached;
    rst = 1'b1;
    in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    ff_in_byte = 8'h00; ff_in_valid = 1'b0; ff_in_last = 1'b0; ff_out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_packed_data), 32'h0);
    check("rst_word_count", 32'(word_count), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      in_byte = vecs[i].b; in_valid = vecs[i].v; in_last = vecs[i].l; out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d_data", i), 32'(out_packed_data), 32'(vecs[i].e_data));
      check($sformatf("v%0d_padded", i), 32'(out_padded), 32'(vecs[i].e_pad));
      check($sformatf("v%0d_last", i), 32'(out_last), 32'(vecs[i].e_last));
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_irdy));
      check($sformatf("v%0d_word_count", i), 32'(word_count), 32'(vecs[i].e_wc));
    end

    // Reset mid-word with a word queued: both must vanish
    in_byte = 8'hAA; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_byte = 8'hC3; in_last = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; in_byte = 8'h55; in_last = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_packed_data), 32'h0);
    check("mid_rst_word_count", 32'(word_count), 32'd0);
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);
    in_byte = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    check("r11_out_valid", 32'(out_valid), 32'd0);
    in_byte = 8'h22;
    @(posedge clk); #1;
    check("r22_out_valid", 32'(out_valid), 32'd1);
    check("r22_data", 32'(out_packed_data), 32'h1122);
    check("r22_padded", 32'(out_padded), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("r22_pop_count", 32'(word_count), 32'd1);
    check("r22_pop_valid", 32'(out_valid), 32'd0);

    // Non-zero pad byte instance
    ff_in_byte = 8'h7E; ff_in_valid = 1'b1; ff_in_last = 1'b1;
    @(posedge clk); #1;
    ff_in_valid = 1'b0;
    check("ff_out_valid", 32'(ff_out_valid), 32'd1);
    check("ff_data", 32'(ff_out_packed_data), 32'h7EFF);
    check("ff_padded", 32'(ff_out_padded), 32'd1);
    check("ff_last", 32'(ff_out_last), 32'd1);

    // word_count wrap: one padded word per cycle, popped every cycle
    in_byte = 8'h5A; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 70000 && !reached; c++) begin
      @(posedge clk); #1;
      if (word_count == 16'hFFFF) reached = 1'b1;
    end
    check("wrap_reach_ffff", 32'(word_count), 32'h0000FFFF);
    check("wrap_pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("wrap_to_zero", 32'(word_count), 32'h0);
    check("wrap_drained", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
